// File: rtl/seq_detect_param.sv
// Serial pattern detector: masked PAT_W-bit compare on qualified bits, one-cycle match pulse, saturating match counter.
// Latency: flag rises one cycle after the edge that samples the completing bit; all outputs are registered.
// Backpressure: none; din_valid low simply holds history, fill and counter.
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter logic [PAT_W-1:0] MASK    = '1,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W  = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_FILL,
        S_ARMED
    } state_t;

    state_t state;
    logic [FILL_W-1:0] fill;

    // Only the older PAT_W-1 bits need storing; the newest bit of the window is din itself.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] win;
    logic             near_full;
    logic             hit;

    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_base;
    logic             sat_nxt;

    always_comb begin
        win       = {hist, din};
        near_full = (state == S_ARMED) || (fill == FILL_W'(PAT_W - 1));
        hit       = din_valid && near_full && (((win ^ PATTERN) & MASK) == '0);
    end

    // Clear is applied before the hit is counted, so clear+hit lands on 1.
    always_comb begin
        cnt_base = clear_cnt ? '0 : match_cnt;
        sat_base = clear_cnt ? 1'b0 : cnt_sat;
        cnt_inc  = cnt_base + CNT_W'(1);
        cnt_nxt  = cnt_base;
        sat_nxt  = sat_base;
        if (hit) begin
            if (cnt_base != CNT_MAX) begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == CNT_MAX) begin
                    sat_nxt = 1'b1;
                end
            end else begin
                sat_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FILL;
            fill      <= '0;
            hist      <= '0;
            flag      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            flag      <= hit;
            match_cnt <= cnt_nxt;
            cnt_sat   <= sat_nxt;
            if (din_valid) begin
                if (hit && !OVERLAP) begin
                    state <= S_FILL;
                    fill  <= '0;
                    hist  <= '0;
                end else begin
                    hist <= win[PAT_W-2:0];
                    if (state == S_FILL) begin
                        fill <= fill + FILL_W'(1);
                        if (fill == FILL_W'(PAT_W - 1)) begin
                            state <= S_ARMED;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector, the successor to the fixed 3-bit "101" detector.
- Sampled 1-bit stream; pattern value, length, don't-care mask and overlap mode are set at elaboration.
- Adds input qualification (din_valid), a registered one-cycle match pulse and a saturating match counter with synchronous clear.
- Sits on serial data paths (frame-sync / preamble hunt) ahead of deframing logic.

Parameters:
- PAT_W, 3: pattern length in bits; legal range 2..32.
- PATTERN, 3'b101: PAT_W bits; PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last.
- MASK, all ones: PAT_W bits; 1 = compare this position, 0 = don't care.
- OVERLAP, 1: 1 = a matched window's bits may start the next match; 0 = history flushed after each match.
- CNT_W, 8: match counter width; legal range 1..32.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high; low cycles are ignored entirely (no shift, no effect on match).
- clear_cnt  in  1  synchronous clear of match_cnt and cnt_sat.
- flag  out  1  one-cycle match pulse, registered.
- match_cnt  out  CNT_W  number of matches since reset/clear, saturating.
- cnt_sat  out  1  sticky; high once match_cnt has reached all-ones.

Behaviour:
- Reset (rst=1 at a rising edge):
  - hist = 0, fill = 0, flag = 0, match_cnt = 0, cnt_sat = 0.
  - Reset overrides all inputs, including a mid-pattern stream; no partial history survives.
- State:
  - hist[PAT_W-1:0] is the shift history.
  - fill (0..PAT_W) counts valid bits held in hist. It acts as the FSM: states FILL_0..FILL_PAT_W-1, then ARMED (fill = PAT_W).
- Valid beat (din_valid=1):
  - win = {hist[PAT_W-2:0], din}; hist <= win.
  - fill <= min(fill+1, PAT_W).
  - hit = ((win ^ PATTERN) & MASK) == 0 AND (fill+1 >= PAT_W).
- Idle cycle (din_valid=0): hist, fill and match_cnt hold; flag <= 0.
- flag timing: flag <= hit.
  - Latency is one cycle: flag is high in the cycle after the edge that sampled the completing bit, and only for that cycle.
  - Back-to-back hits produce consecutive flag cycles.
- Overlap mode:
  - OVERLAP=1: after a hit, fill stays PAT_W (remains ARMED).
  - OVERLAP=0: on a hit, fill <= 0 and hist <= 0, so the next match needs PAT_W fresh valid bits.
- Counter:
  - On a hit with match_cnt != all-ones: match_cnt += 1.
  - At all-ones, match_cnt holds and cnt_sat is set.
- clear_cnt:
  - match_cnt <= 0 and cnt_sat <= 0.
  - It does not touch hist, fill or flag.
  - If clear_cnt and a hit occur in the same cycle, match_cnt <= 1 (clear applied first, then the hit counted) and cnt_sat <= 0.
  - If CNT_W=1, that case sets cnt_sat=1.
- No hit is possible before PAT_W valid bits have been received since reset or since the last non-overlap flush.
- Reset during a valid beat: reset wins; that bit is discarded and flag is 0 in the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Default parameters, din_valid=1, din = 1,0,1,0,1 -> flag pulses one cycle after beats 3 and 5 (2 pulses); match_cnt=2.
- OVERLAP=0, same stream 1,0,1,0,1 -> single flag after beat 3; beats 4-5 give fill=2, no hit; match_cnt=1. Then send 1,0,1 more (beats 6,7,8) -> flag after beat 8.
- Default parameters, din=1 (valid), 2 idle cycles with din=1, din=0 (valid), 1 idle cycle, din=1 (valid) -> exactly one flag, one cycle after the final valid beat; idle-cycle din values are ignored.
- Default parameters, din = 1,0, then rst=1 for one cycle, then din = 1,0,1 -> no flag until the third post-reset bit; match_cnt=1; all outputs 0 during and just after reset.
- CNT_W=2, overlapping stream 1,0,1,0,1,0,1,0,1,0,1 (5 hits) -> match_cnt sequence 1,2,3,3,3; cnt_sat rises with the 3rd hit. Assert clear_cnt coincident with a 6th hit -> match_cnt=1, cnt_sat=0.
- PAT_W=4, PATTERN=4'b1001, MASK=4'b1001 -> streams 1,1,1,1 and 1,0,1,1 each flag; 0,1,1,1 does not; verify flag latency is one cycle.
